// File: rtl/data_ram_pipe_if.sv
// Load-request, store-commit and load-response bus of data_ram_pipe.
interface data_ram_pipe_if #(
  parameter int unsigned TAG_W = 5
);
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [1:0]       ld_size;
  logic             ld_unsigned;
  logic [TAG_W-1:0] ld_tag;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [1:0]       st_size;
  logic [31:0]      st_data;
  logic             rsp_valid;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             rsp_err;
  logic             st_err;

  modport master (
    output ld_valid, ld_addr, ld_size, ld_unsigned, ld_tag,
    output st_valid, st_addr, st_size, st_data,
    input  ld_ready, rsp_valid, rsp_tag, rsp_data, rsp_err, st_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_size, ld_unsigned, ld_tag,
    input  st_valid, st_addr, st_size, st_data,
    output ld_ready, rsp_valid, rsp_tag, rsp_data, rsp_err, st_err
  );
endinterface

// File: rtl/data_ram_pipe.sv
// Pipelined data memory for the load/store path: separate load and store
// ports, byte/half/word access with sign/zero extension, same-cycle
// store-to-load forwarding and an RD_LAT-deep response pipeline.
// Optional macro DATA_RAM_CLEAR_EN adds a zeroing sweep after reset.
module data_ram_pipe #(
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned TAG_W      = 5
) (
  input logic            clk,
  input logic            rst,
  data_ram_pipe_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_W = DEPTH_LOG2;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_CLEAR} state_t;

  state_t           state;
  logic             ready_q;
  logic             st_err_q;
  logic             pipe_valid [RD_LAT];
  logic [TAG_W-1:0] pipe_tag   [RD_LAT];
  logic [31:0]      pipe_data  [RD_LAT];
  logic             pipe_err   [RD_LAT];
  logic [31:0]      mem        [DEPTH];

  logic [IDX_W-1:0] st_idx, ld_idx;
  logic             st_fault, st_wr, ld_fault, ld_acc;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata, ld_word, ld_shift, ld_ext;
`ifdef DATA_RAM_CLEAR_EN
  logic [IDX_W-1:0] clr_idx;
`endif

  function automatic logic fault_f(input logic [31:0] a, input logic [1:0] s);
    logic oor, mis;
    oor = (a >> (DEPTH_LOG2 + 2)) != 32'd0;
    mis = (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
    return oor || mis || (s == 2'd3);
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] lane, input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0001 << lane;
      2'd1:    return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_f(input logic [31:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Store decode, accept-cycle memory read with byte-merged forwarding, extension.
  always_comb begin
    st_idx   = bus.st_addr[DEPTH_LOG2+1:2];
    ld_idx   = bus.ld_addr[DEPTH_LOG2+1:2];
    st_fault = fault_f(bus.st_addr, bus.st_size);
    st_wr    = bus.st_valid && !st_fault && (state == S_RUN) && !rst;
    st_be    = be_f(bus.st_addr[1:0], bus.st_size);
    st_wdata = rep_f(bus.st_data, bus.st_size);
    ld_acc   = bus.ld_valid && ready_q && !rst;
    ld_fault = fault_f(bus.ld_addr, bus.ld_size);
    ld_word  = mem[ld_idx];
    if (st_wr && st_idx == ld_idx) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) ld_word[8*b +: 8] = st_wdata[8*b +: 8];
      end
    end
    ld_shift = ld_word >> {bus.ld_addr[1:0], 3'b000};
    case (bus.ld_size)
      2'd0:    ld_ext = bus.ld_unsigned ? {24'd0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_ext = bus.ld_unsigned ? {16'd0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_word;
    endcase
    if (ld_fault) ld_ext = 32'd0;
  end

  // Memory array: clear sweep or byte-enabled store write; contents survive rst.
  always_ff @(posedge clk) begin
`ifdef DATA_RAM_CLEAR_EN
    if (state == S_CLEAR && !rst) begin
      mem[clr_idx] <= 32'd0;
    end else
`endif
    if (st_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[st_idx][8*b +: 8] <= st_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM, store fault pulse and load response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      ready_q  <= 1'b0;
      st_err_q <= 1'b0;
`ifdef DATA_RAM_CLEAR_EN
      clr_idx  <= '0;
`endif
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_tag[i]   <= '0;
        pipe_data[i]  <= 32'd0;
        pipe_err[i]   <= 1'b0;
      end
    end else begin
      st_err_q <= 1'b0;
      case (state)
        S_RESET: begin
`ifdef DATA_RAM_CLEAR_EN
          state   <= S_CLEAR;
          clr_idx <= '0;
`else
          state   <= S_RUN;
          ready_q <= 1'b1;
`endif
        end
`ifdef DATA_RAM_CLEAR_EN
        S_CLEAR: begin
          st_err_q <= bus.st_valid;
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
`endif
        S_RUN: begin
          st_err_q <= bus.st_valid && st_fault;
        end
        default: begin
          state   <= S_RESET;
          ready_q <= 1'b0;
        end
      endcase
      pipe_valid[0] <= ld_acc;
      pipe_tag[0]   <= ld_acc ? bus.ld_tag : '0;
      pipe_data[0]  <= ld_acc ? ld_ext : 32'd0;
      pipe_err[0]   <= ld_acc && ld_fault;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        pipe_data[i]  <= pipe_data[i-1];
        pipe_err[i]   <= pipe_err[i-1];
      end
    end
  end

  assign bus.ld_ready  = ready_q;
  assign bus.st_err    = st_err_q;
  assign bus.rsp_valid = pipe_valid[RD_LAT-1];
  assign bus.rsp_tag   = pipe_tag[RD_LAT-1];
  assign bus.rsp_data  = pipe_data[RD_LAT-1];
  assign bus.rsp_err   = pipe_err[RD_LAT-1];
endmodule

// File: tb/tb_data_ram_pipe.sv
// Directed, table-driven bench for data_ram_pipe (DEPTH_LOG2=6, RD_LAT=2).
module tb_data_ram_pipe;
  localparam int unsigned TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_ram_pipe_if #(.TAG_W(TAG_W)) bus ();

  data_ram_pipe #(.DEPTH_LOG2(6), .RD_LAT(2), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        ld_v;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_uns;
    logic [4:0]  ld_tag;
    logic        st_v;
    logic [31:0] st_addr;
    logic [1:0]  st_size;
    logic [31:0] st_data;
    logic [31:0] exp_data;
    logic        exp_rerr;
    logic        exp_serr;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid = 1'b0; bus.ld_addr = 32'd0; bus.ld_size = 2'd0;
    bus.ld_unsigned = 1'b0; bus.ld_tag = '0;
    bus.st_valid = 1'b0; bus.st_addr = 32'd0; bus.st_size = 2'd0; bus.st_data = 32'd0;
  endtask

  task automatic drive_ld(input logic [31:0] a, input logic [1:0] s, input logic u, input logic [4:0] t);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_size = s; bus.ld_unsigned = u; bus.ld_tag = t;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    bus.st_valid = 1'b1; bus.st_addr = a; bus.st_size = s; bus.st_data = d;
  endtask

  // Single load with full latency check.
  task automatic do_load(input string name, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [4:0] t, input logic [31:0] exp);
    drive_ld(a, s, u, t);
    step();
    idle();
    chk({name, " early"}, 32'(bus.rsp_valid), 32'd0);
    step();
    chk({name, " valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({name, " tag"}, 32'(bus.rsp_tag), 32'(t));
    chk({name, " data"}, bus.rsp_data, exp);
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] la, input logic [1:0] ls,
                              input logic lu, input logic [4:0] lt,
                              input logic sv, input logic [31:0] sa, input logic [1:0] ss,
                              input logic [31:0] sd, input logic [31:0] ed,
                              input logic er, input logic es);
    vec_t v;
    v.ld_v = lv; v.ld_addr = la; v.ld_size = ls; v.ld_uns = lu; v.ld_tag = lt;
    v.st_v = sv; v.st_addr = sa; v.st_size = ss; v.st_data = sd;
    v.exp_data = ed; v.exp_rerr = er; v.exp_serr = es;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cnt;
    //              ld  addr   sz u tag  st addr    sz data           exp data      rerr serr
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h10,  2, 32'h8000_00FF, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h10, 2, 0, 3,  0, 32'h00,  0, 32'h0,         32'h8000_00FF, 0, 0));
    vecs.push_back(mk(1, 32'h10, 0, 0, 4,  0, 32'h00,  0, 32'h0,         32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mk(1, 32'h13, 0, 1, 5,  0, 32'h00,  0, 32'h0,         32'h0000_0080, 0, 0));
    vecs.push_back(mk(1, 32'h12, 1, 0, 6,  0, 32'h00,  0, 32'h0,         32'hFFFF_8000, 0, 0));
    vecs.push_back(mk(1, 32'h10, 1, 1, 7,  0, 32'h00,  0, 32'h0,         32'h0000_00FF, 0, 0));
    vecs.push_back(mk(1, 32'h10, 2, 0, 8,  1, 32'h11,  0, 32'h0000_00AB, 32'h8000_ABFF, 0, 0));
    vecs.push_back(mk(1, 32'h10, 2, 0, 9,  0, 32'h00,  0, 32'h0,         32'h8000_ABFF, 0, 0));
    vecs.push_back(mk(1, 32'h11, 1, 0, 10, 0, 32'h00,  0, 32'h0,         32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h00,  2, 32'h1122_3344, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h102, 2, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1));
    vecs.push_back(mk(1, 32'h00, 2, 0, 11, 0, 32'h00,  0, 32'h0,         32'h1122_3344, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h11,  1, 32'h0000_5555, 32'h0000_0000, 0, 1));
    vecs.push_back(mk(1, 32'h10, 2, 0, 12, 0, 32'h00,  0, 32'h0,         32'h8000_ABFF, 0, 0));
    vecs.push_back(mk(1, 32'h100,2, 0, 13, 0, 32'h00,  0, 32'h0,         32'h0000_0000, 1, 0));
    vecs.push_back(mk(1, 32'h10, 3, 0, 14, 0, 32'h00,  0, 32'h0,         32'h0000_0000, 1, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h12,  0, 32'hFFFF_FF7F, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h12, 0, 0, 15, 0, 32'h00,  0, 32'h0,         32'h0000_007F, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h12,  1, 32'h0000_C001, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h12, 1, 0, 16, 0, 32'h00,  0, 32'h0,         32'hFFFF_C001, 0, 0));
    vecs.push_back(mk(1, 32'h10, 2, 0, 17, 1, 32'h11,  2, 32'h0000_0000, 32'hC001_ABFF, 0, 1));
    vecs.push_back(mk(1, 32'h10, 2, 0, 18, 1, 32'h14,  2, 32'h0102_0304, 32'hC001_ABFF, 0, 0));
    vecs.push_back(mk(1, 32'h14, 2, 0, 19, 0, 32'h00,  0, 32'h0,         32'h0102_0304, 0, 0));
    vecs.push_back(mk(1, 32'h16, 1, 0, 20, 1, 32'h16,  1, 32'h0000_8765, 32'hFFFF_8765, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,  1, 32'h20,  2, 32'hCAFE_F00D, 32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 32'h21, 0, 0, 21, 0, 32'h00,  0, 32'h0,         32'hFFFF_FFF0, 0, 0));
    vecs.push_back(mk(1, 32'hFC, 2, 0, 22, 1, 32'hFC,  2, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 0));
    vecs.push_back(mk(1, 32'hFE, 1, 1, 23, 0, 32'h00,  0, 32'h0,         32'h0000_A5A5, 0, 0));
    vecs.push_back(mk(1, 32'h12, 2, 0, 24, 0, 32'h00,  0, 32'h0,         32'h0000_0000, 1, 0));
    vecs.push_back(mk(1, 32'h22, 0, 1, 25, 1, 32'h23,  0, 32'h0000_0011, 32'h0000_00FE, 0, 0));
    vecs.push_back(mk(1, 32'h20, 2, 0, 26, 0, 32'h00,  0, 32'h0,         32'h11FE_F00D, 0, 0));

    // Reset state.
    idle();
    rst = 1'b1;
    step(); step(); step();
    chk("rst ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_tag", 32'(bus.rsp_tag), 32'd0);
    chk("rst rsp_data", bus.rsp_data, 32'd0);
    chk("rst rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst st_err", 32'(bus.st_err), 32'd0);
    rst = 1'b0;
    step();
`ifdef DATA_RAM_CLEAR_EN
    chk("clear ld_ready low", 32'(bus.ld_ready), 32'd0);
    drive_st(32'h10, 2'd2, 32'h0000_0077);
    step();
    idle();
    chk("clear st_err", 32'(bus.st_err), 32'd1);
    cnt = 2;
    while (!bus.ld_ready && cnt < 200) begin
      step();
      cnt++;
    end
    chk("clear ld_ready rises", 32'(bus.ld_ready), 32'd1);
    chk("clear length", 32'(cnt >= 64), 32'd1);
    do_load("clear lw", 32'h10, 2'd2, 1'b0, 5'd1, 32'd0);
`else
    chk("run ld_ready", 32'(bus.ld_ready), 32'd1);
`endif

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.ld_v) drive_ld(v.ld_addr, v.ld_size, v.ld_uns, v.ld_tag);
      if (v.st_v) drive_st(v.st_addr, v.st_size, v.st_data);
      step();
      idle();
      chk($sformatf("v%0d st_err", i), 32'(bus.st_err), 32'(v.exp_serr));
      chk($sformatf("v%0d rsp early", i), 32'(bus.rsp_valid), 32'd0);
      step();
      chk($sformatf("v%0d st_err pulse", i), 32'(bus.st_err), 32'd0);
      chk($sformatf("v%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(v.ld_v));
      if (v.ld_v) begin
        chk($sformatf("v%0d rsp_tag", i), 32'(bus.rsp_tag), 32'(v.ld_tag));
        chk($sformatf("v%0d rsp_err", i), 32'(bus.rsp_err), 32'(v.exp_rerr));
      end
      chk($sformatf("v%0d rsp_data", i), bus.rsp_data, v.exp_data);
    end

    // Snapshot at accept: a later store must not affect the load.
    drive_ld(32'h20, 2'd2, 1'b0, 5'd9);
    step();
    idle();
    drive_st(32'h20, 2'd2, 32'h1234_5678);
    step();
    idle();
    chk("snap valid", 32'(bus.rsp_valid), 32'd1);
    chk("snap data", bus.rsp_data, 32'h11FE_F00D);
    do_load("snap after", 32'h20, 2'd2, 1'b0, 5'd10, 32'h1234_5678);

    // Four back-to-back loads, in-order responses.
    for (int j = 1; j <= 6; j++) begin
      if (j <= 4) drive_ld(32'h10, 2'd2, 1'b0, 5'(j));
      else idle();
      step();
      chk($sformatf("b2b valid e%0d", j), 32'(bus.rsp_valid), 32'((j >= 2) && (j <= 5)));
      if (j >= 2 && j <= 5) begin
        chk($sformatf("b2b tag e%0d", j), 32'(bus.rsp_tag), 32'(j - 1));
        chk($sformatf("b2b data e%0d", j), bus.rsp_data, 32'hC001_ABFF);
      end
    end
    idle();

    // Reset the cycle after the second accept kills in-flight loads.
    drive_ld(32'h10, 2'd2, 1'b0, 5'd1);
    step();
    drive_ld(32'h10, 2'd2, 1'b0, 5'd2);
    step();
    chk("kill tag1 out", 32'(bus.rsp_valid), 32'd1);
    drive_ld(32'h10, 2'd2, 1'b0, 5'd3);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("kill rsp_valid r%0d", j), 32'(bus.rsp_valid), 32'd0);
    end
    idle();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("kill rsp_valid p%0d", j), 32'(bus.rsp_valid), 32'd0);
    end
    do_load("mem kept", 32'h10, 2'd2, 1'b0, 5'd7, 32'hC001_ABFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
